mem_bus_arbiter: RTL and testbench

Parametrised arbiter that shares one single-ported memory between NUM_PORTS requesters (port 0 = instruction fetch, port 1 = data access in the two-port core). It registers the winning request, drives the memory until `mem_ready`, then returns read data and a one-cycle `ready` pulse to the granted port only. Unlike the combinational imem/dmem steering it replaces, it supports writes, more than two ports, and selectable fixed or round-robin priority.

---
 rtl/mem_bus_arbiter.sv | 141 ++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Shares one single-ported memory between NUM_PORTS requesters through an IDLE/BUSY/DONE handshake.
// Define ROUND_ROBIN_EN for rotating priority; otherwise the highest-index requester wins.
module mem_bus_arbiter #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_PORTS-1:0]            req,
  input  logic [NUM_PORTS-1:0]            we,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0]           rdata,
  output logic [NUM_PORTS-1:0]            ready,
  output logic                            mem_req,
  output logic                            mem_we,
  output logic [ADDR_WIDTH-1:0]           mem_addr,
  output logic [DATA_WIDTH-1:0]           mem_wdata,
  input  logic [DATA_WIDTH-1:0]           mem_rdata,
  input  logic                            mem_ready
);

  localparam int GW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e                  state_q;
  logic [GW-1:0]           gnt_q;
  logic [GW-1:0]           gnt_d;
  logic                    any_req;
  logic                    mem_req_q;
  logic                    mem_we_q;
  logic [ADDR_WIDTH-1:0]   mem_addr_q;
  logic [DATA_WIDTH-1:0]   mem_wdata_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic [NUM_PORTS-1:0]    ready_q;
  logic                    sel_we;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_wdata;
`ifdef ROUND_ROBIN_EN
  logic [GW-1:0]           ptr_q;
`endif

  assign any_req = |req;

`ifdef ROUND_ROBIN_EN
  // Walk from the far end of the rotation so the port closest after ptr_q is assigned last and wins.
  always_comb begin : pick_winner
    logic [GW-1:0] idx;
    gnt_d = '0;
    idx   = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      idx = GW'((int'(ptr_q) + 1 + i) % NUM_PORTS);
      if (req[idx]) gnt_d = idx;
    end
  end
`else
  always_comb begin : pick_winner
    gnt_d = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (req[p]) gnt_d = GW'(p);
    end
  end
`endif

  always_comb begin : mux_winner
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (gnt_d == GW'(p)) begin
        sel_we    = we[p];
        sel_addr  = addr[p*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = wdata[p*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // DONE exists so the winner's still-high req is not re-granted before it sees its ready pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      ready_q     <= '0;
`ifdef ROUND_ROBIN_EN
      ptr_q       <= GW'(NUM_PORTS - 1);
`endif
    end else begin
      case (state_q)
        IDLE: begin
          ready_q <= '0;
          rdata_q <= '0;
          if (any_req) begin
            gnt_q       <= gnt_d;
            mem_req_q   <= 1'b1;
            mem_we_q    <= sel_we;
            mem_addr_q  <= sel_addr;
            mem_wdata_q <= sel_wdata;
`ifdef ROUND_ROBIN_EN
            ptr_q       <= gnt_d;
`endif
            state_q     <= BUSY;
          end
        end
        BUSY: begin
          if (mem_ready) begin
            rdata_q   <= mem_rdata;
            ready_q   <= NUM_PORTS'(1) << gnt_q;
            mem_req_q <= 1'b0;
            state_q   <= DONE;
          end
        end
        DONE: begin
          ready_q <= '0;
          rdata_q <= '0;
          state_q <= IDLE;
        end
        default: begin
          state_q   <= IDLE;
          mem_req_q <= 1'b0;
          ready_q   <= '0;
          rdata_q   <= '0;
        end
      endcase
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rdata     = rdata_q;
  assign ready     = ready_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: requests push expected transactions, ready pulses pop and compare.
// Built with ROUND_ROBIN_EN it runs four ports and checks the rotating grant order.
module tb_mem_bus_arbiter;

`ifdef ROUND_ROBIN_EN
  localparam int NP = 4;
`else
  localparam int NP = 2;
`endif

  typedef struct {
    int          port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          issueCycle;
  } txn_t;

  logic             clk;
  logic             rst_n;
  logic [NP-1:0]    req;
  logic [NP-1:0]    we;
  logic [NP*32-1:0] addr;
  logic [NP*32-1:0] wdata;
  logic [31:0]      rdata;
  logic [NP-1:0]    ready;
  logic             mem_req;
  logic             mem_we;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_wdata;
  logic [31:0]      mem_rdata;
  logic             mem_ready;

  txn_t expQ[$];
  int   readyPortLog[$];
  int   readyCycleLog[$];
  int   riseCycleLog[$];
  int   weLog[$];

  int   checks = 0;
  int   failures = 0;
  int   cycle = 0;
  int   rrPtr = NP - 1;
  int   curPort = 0;
  int   curWait = 0;
  int   nextWait = 0;
  int   waitCnt = 0;
  int   memReqRun = 0;
  int   lastLatency = 0;
  bit   randomWait = 0;
  bit   forceReady = 0;
  bit   autoReissue = 0;
  bit   monEn = 0;
  bit   memReqPrev = 0;
  logic [63:0] latchAW;

  mem_bus_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ready(ready), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something wedges outside the bounded waits
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cycle);
    end
  endtask

  function automatic logic [31:0] memResp(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'hDEAD_BEEF;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic int pickWinner(input logic [NP-1:0] r, input int ptr);
    int c;
`ifdef ROUND_ROBIN_EN
    for (int k = 1; k <= NP; k++) begin
      c = (ptr + k) % NP;
      if (r[c]) return c;
    end
`else
    for (c = NP - 1; c >= 0; c--) begin
      if (r[c]) return c;
    end
`endif
    return -1;
  endfunction

  function automatic int findExp(input int p);
    foreach (expQ[i]) begin
      if (expQ[i].port == p) return i;
    end
    return -1;
  endfunction

  // Raise one port's request and record what the memory and the port should see
  task automatic applyStimulus(input int p, input logic w, input logic [31:0] a, input logic [31:0] d);
    txn_t t;
    req[p] = 1'b1;
    we[p] = w;
    addr[p*32 +: 32] = a;
    wdata[p*32 +: 32] = d;
    t.port = p;
    t.we = w;
    t.addr = a;
    t.wdata = d;
    t.rdata = memResp(a);
    t.issueCycle = cycle;
    expQ.push_back(t);
  endtask

  // One clock: monitor outputs at the falling edge, then update requesters and the memory model
  task automatic tick();
    logic [NP-1:0] reqAtEdge;
    int p;
    int idx;
    int rp;
    txn_t t;
    reqAtEdge = req;
    if (!rst_n) rrPtr = NP - 1;
    @(negedge clk);
    cycle++;
    if (monEn) begin
      if (mem_req && !memReqPrev) begin
        p = pickWinner(reqAtEdge, rrPtr);
        if (p >= 0) rrPtr = p;
        idx = findExp(p);
        checkOutput("grantFound", 64'(idx >= 0), 64'd1);
        if (idx >= 0) begin
          checkOutput("grantWe", 64'(mem_we), 64'(expQ[idx].we));
          checkOutput("grantAddr", 64'(mem_addr), 64'(expQ[idx].addr));
          if (expQ[idx].we) checkOutput("grantWdata", 64'(mem_wdata), 64'(expQ[idx].wdata));
        end
        curPort = p;
        latchAW = {mem_addr, mem_wdata};
        memReqRun = 1;
        riseCycleLog.push_back(cycle);
        weLog.push_back(int'(mem_we));
        curWait = randomWait ? int'($urandom_range(0, 3)) : nextWait;
        waitCnt = 0;
      end else if (mem_req) begin
        memReqRun++;
        checkOutput("stableAddrData", {mem_addr, mem_wdata}, latchAW);
      end
      if (ready != '0) begin
        rp = -1;
        for (int b = 0; b < NP; b++) if (ready[b]) rp = b;
        checkOutput("readyOneHot", 64'(ready), 64'(NP'(1) << curPort));
        checkOutput("memReqLen", 64'(memReqRun), 64'(curWait + 1));
        idx = findExp(curPort);
        checkOutput("readyFound", 64'(idx >= 0), 64'd1);
        if (idx >= 0) begin
          checkOutput("rdata", 64'(rdata), 64'(expQ[idx].rdata));
          lastLatency = cycle - expQ[idx].issueCycle;
          t = expQ[idx];
          expQ.delete(idx);
          if (autoReissue) begin
            t.issueCycle = cycle;
            expQ.push_back(t);
          end
        end
        readyPortLog.push_back(rp);
        readyCycleLog.push_back(cycle);
        if (!autoReissue && curPort >= 0) req[curPort] = 1'b0;
      end else begin
        checkOutput("rdataIdle", 64'(rdata), 64'd0);
      end
    end
    memReqPrev = mem_req;
    if (forceReady) begin
      mem_ready = 1'b1;
      mem_rdata = $urandom;
    end else if (mem_req && waitCnt == curWait) begin
      mem_ready = 1'b1;
      mem_rdata = memResp(mem_addr);
      waitCnt = 0;
    end else begin
      mem_ready = 1'b0;
      mem_rdata = $urandom;
      if (mem_req) waitCnt++;
    end
  endtask

  task automatic waitIdle(input int maxCycles);
    int n;
    n = 0;
    while ((req != '0 || expQ.size() != 0 || mem_req || ready != '0) && n < maxCycles) begin
      tick();
      n++;
    end
    checkOutput("drainInTime", 64'(n < maxCycles), 64'd1);
  endtask

  task automatic clearLogs();
    readyPortLog.delete();
    readyCycleLog.delete();
    riseCycleLog.delete();
    weLog.delete();
  endtask

  initial begin
    rst_n = 1'b0;
    req = '0;
    we = '0;
    addr = '0;
    wdata = '0;
    mem_ready = 1'b0;
    mem_rdata = '0;

    // Reset with every port requesting: outputs must stay cleared
    $display("[TB] reset with all requests high");
    for (int p = 0; p < NP; p++) applyStimulus(p, 1'b0, 32'h40 + 32'(p * 4), 32'h0);
    tick();
    tick();
    checkOutput("rstMemReq", 64'(mem_req), 64'd0);
    checkOutput("rstMemWe", 64'(mem_we), 64'd0);
    checkOutput("rstMemAddr", 64'(mem_addr), 64'd0);
    checkOutput("rstMemWdata", 64'(mem_wdata), 64'd0);
    checkOutput("rstRdata", 64'(rdata), 64'd0);
    checkOutput("rstReady", 64'(ready), 64'd0);
    rst_n = 1'b1;
    monEn = 1'b1;
    clearLogs();
`ifdef ROUND_ROBIN_EN
    autoReissue = 1'b1;
    nextWait = 0;
    for (int n = 0; n < 80 && readyPortLog.size() < 5; n++) tick();
    autoReissue = 1'b0;
    checkOutput("rrCount", 64'(readyPortLog.size() >= 5), 64'd1);
    if (readyPortLog.size() >= 5) begin
      checkOutput("rrOrder0", 64'(readyPortLog[0]), 64'd0);
      checkOutput("rrOrder1", 64'(readyPortLog[1]), 64'd1);
      checkOutput("rrOrder2", 64'(readyPortLog[2]), 64'd2);
      checkOutput("rrOrder3", 64'(readyPortLog[3]), 64'd3);
      checkOutput("rrOrder4", 64'(readyPortLog[4]), 64'd0);
      checkOutput("rrPeriod", 64'(readyCycleLog[4] - readyCycleLog[0]), 64'd12);
    end
    waitIdle(200);
`else
    waitIdle(200);
    checkOutput("rstOrderCount", 64'(readyPortLog.size()), 64'd2);
    if (readyPortLog.size() >= 2) begin
      checkOutput("rstFirstGrant", 64'(readyPortLog[0]), 64'(NP - 1));
      checkOutput("rstSecondGrant", 64'(readyPortLog[1]), 64'd0);
    end
`endif

    // Single read with two memory wait cycles
    $display("[TB] single read from port 0");
    tick();
    clearLogs();
    nextWait = 2;
    applyStimulus(0, 1'b0, 32'h0000_0100, 32'h0);
    waitIdle(50);
    checkOutput("singleLatency", 64'(lastLatency), 64'd4);
    checkOutput("singlePort", 64'(readyPortLog.size() == 1 && readyPortLog[0] == 0), 64'd1);

    // Two ports together; the write lands first under fixed priority
    $display("[TB] two-port conflict");
    tick();
    clearLogs();
    nextWait = 1;
    applyStimulus(0, 1'b0, 32'h0000_0200, 32'h0);
    applyStimulus(1, 1'b1, 32'h0000_0080, 32'h1234_5678);
    waitIdle(60);
    checkOutput("conflictCount", 64'(readyPortLog.size()), 64'd2);
    if (readyPortLog.size() >= 2 && riseCycleLog.size() >= 2) begin
`ifndef ROUND_ROBIN_EN
      checkOutput("conflictFirst", 64'(readyPortLog[0]), 64'd1);
      checkOutput("conflictSecond", 64'(readyPortLog[1]), 64'd0);
      checkOutput("conflictFirstWe", 64'(weLog[0]), 64'd1);
`endif
      checkOutput("conflictIdleGap", 64'(riseCycleLog[1] - readyCycleLog[0] - 1), 64'd1);
    end

    // Random traffic with random memory latency
    $display("[TB] random traffic");
    randomWait = 1'b1;
    for (int n = 0; n < 40; n++) begin
      int p;
      p = int'($urandom_range(0, NP - 1));
      if (!req[p]) applyStimulus(p, 1'($urandom_range(0, 1)), $urandom, $urandom);
      tick();
      if ($urandom_range(0, 1) == 1) tick();
    end
    waitIdle(400);
    randomWait = 1'b0;

    // Reset in the middle of a long access, with the strobe arriving at the reset edge
    $display("[TB] reset while busy");
    nextWait = 10;
    applyStimulus(0, 1'b0, 32'h0000_0300, 32'h0);
    tick();
    tick();
    tick();
    checkOutput("midBusyMemReq", 64'(mem_req), 64'd1);
    req = '0;
    expQ.delete();
    mem_ready = 1'b1;
    forceReady = 1'b1;
    rst_n = 1'b0;
    tick();
    checkOutput("midRstReady", 64'(ready), 64'd0);
    checkOutput("midRstMemReq", 64'(mem_req), 64'd0);
    rst_n = 1'b1;
    tick();
    forceReady = 1'b0;
    tick();
    checkOutput("postRstReady", 64'(ready), 64'd0);
    checkOutput("postRstMemReq", 64'(mem_req), 64'd0);
    nextWait = 0;
    applyStimulus(NP - 1, 1'b0, 32'h0000_0500, 32'h0);
    waitIdle(40);
    checkOutput("minLatency", 64'(lastLatency), 64'd2);

    // Memory strobe while idle must be ignored
    $display("[TB] stray strobe while idle");
    tick();
    forceReady = 1'b1;
    tick();
    forceReady = 1'b0;
    tick();
    checkOutput("strayReady", 64'(ready), 64'd0);
    checkOutput("strayRdata", 64'(rdata), 64'd0);
    checkOutput("strayMemReq", 64'(mem_req), 64'd0);
    tick();
    checkOutput("strayReadyLater", 64'(ready), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
